// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-CH stream demultiplexer with packet-locked routing.
//
// The destination selector is sampled on the first beat of a packet and held
// until the beat carrying in_last. Each output channel has its own one-entry
// register, so a stalled consumer only backpressures packets aimed at it.
// A first beat whose selector is >= CH drops the whole packet and pulses err.
//
// Optional feature macro: DEMUX_BCAST_EN
//   When defined, adds the bcast input. A packet whose first beat has bcast
//   high is written to every channel at once, with no partial writes.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    input word (WIDTH)
//   in_sel     destination channel, sampled on first beat (SEL_W)
//   in_last    final beat of packet
//   in_valid   input word present
//   bcast      broadcast request, sampled with in_sel (DEMUX_BCAST_EN only)
//   in_ready   input word accepted when in_valid is also high
//   out_data   channel k at [k*WIDTH +: WIDTH]
//   out_last   per-channel last flag
//   out_valid  per-channel word present
//   out_ready  per-channel consumer ready
//   err        one-cycle pulse after accepting a first beat with in_sel >= CH
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SEL_W = $clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_last,
  input  logic                  in_valid,
`ifdef DEMUX_BCAST_EN
  input  logic                  bcast,
`endif
  output logic                  in_ready,
  output logic [CH*WIDTH-1:0]   out_data,
  output logic [CH-1:0]         out_last,
  output logic [CH-1:0]         out_valid,
  input  logic [CH-1:0]         out_ready,
  output logic                  err
);

  typedef enum logic {
    IDLE,
    PKT
  } state_t;

  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CH);

  state_t           state, state_nx;
  logic [SEL_W-1:0] cur_sel;
  logic [SEL_W-1:0] target;
  logic             first_beat;
  logic             target_bad;
  logic             bcast_eff;
  logic             accept;
  logic             err_nx;
  logic [CH-1:0]    can_take;
  logic [CH-1:0]    load;

`ifdef DEMUX_BCAST_EN
  logic bcast_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcast_q <= 1'b0;
    end else if (accept && first_beat) begin
      bcast_q <= bcast;
    end
  end

  assign bcast_eff = first_beat ? bcast : bcast_q;
`else
  assign bcast_eff = 1'b0;
`endif

  always_comb begin
    first_beat = (state == IDLE);
    // An out-of-range selector is latched into cur_sel as-is, so the rest of
    // the packet stays out of range and is dropped without a separate flag.
    target     = first_beat ? in_sel : cur_sel;
    target_bad = ({1'b0, target} >= CH_LIM);
    can_take   = ~out_valid | out_ready;

    in_ready = 1'b0;
    if (bcast_eff) begin
      in_ready = &can_take;
    end else if (target_bad) begin
      in_ready = 1'b1;
    end else begin
      for (int unsigned k = 0; k < CH; k++) begin
        if (target == SEL_W'(k)) begin
          in_ready = can_take[k];
        end
      end
    end

    accept = in_valid && in_ready;

    load = '0;
    if (accept) begin
      if (bcast_eff) begin
        load = '1;
      end else if (!target_bad) begin
        for (int unsigned k = 0; k < CH; k++) begin
          if (target == SEL_W'(k)) begin
            load[k] = 1'b1;
          end
        end
      end
    end

    err_nx = accept && first_beat && target_bad && !bcast_eff;

    state_nx = state;
    case (state)
      IDLE: if (accept && !in_last) state_nx = PKT;
      PKT:  if (accept && in_last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur_sel <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= err_nx;
      if (accept && first_beat) begin
        cur_sel <= in_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_last  <= '0;
      out_data  <= '0;
    end else begin
      for (int unsigned k = 0; k < CH; k++) begin
        if (load[k]) begin
          out_data[k*WIDTH +: WIDTH] <= in_data;
          out_last[k]                <= in_last;
          out_valid[k]               <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule
